nal_stream_arbiter: RTL and testbench
=====================================

# nal_stream_arbiter

Round-robin arbiter that shares one NAL parser byte input among `N_SRC` camera bitstream sources. Grants are made at NAL-unit granularity, so a NAL unit is never interleaved with bytes from another camera. The arbiter tags each forwarded byte with its source ID. It guards the parser's 384-byte NAL buffer with a length limit, and a stall watchdog keeps a dead camera from holding the grant. The block sits between the per-camera byte streams and the parser's `bitstream_data`/`bitstream_valid` input.

## Interface
- `N_SRC`, 4 — number of camera sources (2..8).
- `MAX_NAL_BYTES`, 384 — maximum bytes forwarded per NAL unit; matches the parser buffer (3072 bits).
- `TIMEOUT`, 1024 — consecutive stall cycles mid-NAL before the grant is revoked (≥2).
- `clk` in 1 — single clock; all logic rising-edge.
- `reset_n` in 1 — asynchronous, active-low reset.
- `src_data` in `N_SRC*8` — byte from source i at bits [8i+7:8i].
- `src_valid` in `N_SRC` — source i byte valid.
- `src_last` in `N_SRC` — source i byte is the final byte of its NAL unit.
- `src_ready` out `N_SRC` — source i byte accepted when valid&ready.
- `out_data` out 8 — byte to the parser's `bitstream_data`.
- `out_valid` out 1 — drives the parser's `bitstream_valid`.
- `out_last` out 1 — forwarded byte ends a NAL unit.
- `out_src` out `clog2(N_SRC)` — source ID of the forwarded byte.
- `err_oversize` out 1 — one-cycle pulse; NAL exceeded `MAX_NAL_BYTES`.
- `err_timeout` out 1 — one-cycle pulse; granted source stalled `TIMEOUT` cycles.
- `err_src` out `clog2(N_SRC)` — source of the latest error; holds until the next error.
- `busy` out 1 — high in STREAM or DRAIN.

## Operation
- **States:** ARB, STREAM, DRAIN. Registers: `grant`, `rr_ptr`, `byte_cnt` (width `clog2(MAX_NAL_BYTES+1)`), `stall_cnt` (width `clog2(TIMEOUT+1)`).
- **ARB:**
  - Search `src_valid` starting at `rr_ptr` and wrapping modulo `N_SRC`.
  - Set `grant` to the first valid source, clear `byte_cnt` and `stall_cnt`, then go to STREAM.
  - With no valid source, remain in ARB.
  - All `src_ready` are low in ARB.
- **STREAM:**
  - `src_ready[grant]`=1; all others 0. `src_ready` decodes from registered state only.
  - **Handshake:** forward the byte, increment `byte_cnt`, clear `stall_cnt`.
  - **Handshake with `src_last`:** set `out_last`, set `rr_ptr`=`grant`+1 (mod `N_SRC`), go to ARB.
  - **Handshake when `byte_cnt`==`MAX_NAL_BYTES` (the byte would be number MAX+1):**
    - Do not forward the byte; pulse `err_oversize` and set `err_src`.
    - If that byte carries `src_last`, set `rr_ptr`=`grant`+1 and go to ARB; otherwise go to DRAIN.
  - A last byte at exactly `MAX_NAL_BYTES` is legal and is forwarded normally.
  - **No handshake:** increment `stall_cnt`. When it reaches `TIMEOUT`:
    - pulse `err_timeout` and set `err_src`;
    - set `rr_ptr`=`grant`+1 and go to ARB.
  - The remainder of that source's NAL unit is later arbitrated as a new unit; the parser resynchronises on start codes.
- **DRAIN:**
  - `src_ready[grant]`=1 and `out_valid`=0; bytes are discarded.
  - On a handshake with `src_last`: set `rr_ptr`=`grant`+1 and go to ARB.
  - The stall watchdog also runs in DRAIN: on timeout, pulse `err_timeout` and go to ARB.
- **Simultaneous events:** a handshake in the cycle `stall_cnt` would reach `TIMEOUT` counts as a handshake, so no timeout occurs. Oversize and last on the same byte follow the oversize rule above.

## Timing
- **Reset values:** state=ARB, `rr_ptr`=0, `grant`=0; all counters 0. All outputs 0: `src_ready`, `out_*`, `err_*`, `busy`.
- **Reset mid-NAL:** returns to ARB immediately; no `out_last` is emitted.
- **Output registers:** `out_data`, `out_valid`, `out_last`, `out_src` are registered. A handshake in cycle t appears at the outputs in cycle t+1. `out_valid` is high only for that one cycle per byte.
- **Grant turnaround:** ARB takes one cycle.
  - A source that is valid in ARB cycle t gets ready in cycle t+1.
  - First byte out: t+2.
  - Gap between consecutive NAL units: at least one idle `out_valid` cycle.
- **Error pulses:** `err_*` are registered and one cycle wide. They assert in the cycle after the triggering handshake or stall count.
- **Throughput:** one byte per cycle within a NAL unit.

## Test plan
1. **Single source.** Source 0 sends a 10-byte NAL with no stalls.
   - Required: `out_valid` runs 10 consecutive cycles starting 2 cycles after first valid; `out_src`=0; `out_last` on byte 10; then ARB.
2. **Round robin.** Sources 0, 1, 3 are continuously valid with 4-byte NALs.
   - Required: output order 0,1,3,0,1,3; no interleaving inside a NAL; one idle cycle between NALs.
3. **Oversize.** Source 2 sends a 400-byte NAL.
   - Required: exactly 384 bytes forwarded with no `out_last`; `err_oversize` pulses once with `err_src`=2; bytes 385–400 are accepted and dropped; next grant goes to source 3 or the next valid source.
4. **Boundary length.** Source 1 sends exactly 384 bytes with `src_last` on byte 384.
   - Required: all 384 bytes forwarded, `out_last` set, no error.
5. **Stall.** Source 0 stops after 5 bytes with `TIMEOUT`=16.
   - Required: `err_timeout` pulses after 16 stall cycles with `err_src`=0; source 1 is granted next.
   - A valid arriving on stall cycle 16 must instead be accepted with no error.
6. **Reset mid-NAL.** Drop `reset_n` during byte 3 of a NAL.
   - Required: all outputs go to 0 asynchronously; after release, arbitration restarts from source 0.

Source files
------------

// File: rtl/nal_stream_arbiter_if.sv
// Byte-stream bundle between the camera sources, the NAL arbiter and the parser input.
// The slave modport is the arbiter side; the master modport drives the sources and observes the outputs.
interface nal_stream_arbiter_if #(
    parameter int unsigned N_SRC = 4
);
    localparam int unsigned SW = $clog2(N_SRC);

    logic [N_SRC*8-1:0] src_data;
    logic [N_SRC-1:0]   src_valid;
    logic [N_SRC-1:0]   src_last;
    logic [N_SRC-1:0]   src_ready;
    logic [7:0]         out_data;
    logic               out_valid;
    logic               out_last;
    logic [SW-1:0]      out_src;
    logic               err_oversize;
    logic               err_timeout;
    logic [SW-1:0]      err_src;
    logic               busy;

    modport slave (
        input  src_data, src_valid, src_last,
        output src_ready, out_data, out_valid, out_last, out_src,
        output err_oversize, err_timeout, err_src, busy
    );

    modport master (
        output src_data, src_valid, src_last,
        input  src_ready, out_data, out_valid, out_last, out_src,
        input  err_oversize, err_timeout, err_src, busy
    );
endinterface

// File: rtl/nal_stream_arbiter.sv
// Round-robin arbiter that grants a NAL parser input to one camera for a whole NAL unit,
// with a per-unit length limit and a stall watchdog.
module nal_stream_arbiter #(
    parameter int unsigned N_SRC         = 4,
    parameter int unsigned MAX_NAL_BYTES = 384,
    parameter int unsigned TIMEOUT       = 1024
) (
    input logic             clk,
    input logic             reset_n,
    nal_stream_arbiter_if.slave bus
);
    localparam int unsigned SW = $clog2(N_SRC);
    localparam int unsigned BW = $clog2(MAX_NAL_BYTES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StArb, StStream, StDrain} state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] grant_q, grant_d, rr_ptr_q, rr_ptr_d, grant_next;
    logic [BW-1:0] byte_cnt_q, byte_cnt_d;
    logic [TW-1:0] stall_cnt_q, stall_cnt_d;
    logic [7:0]    out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [SW-1:0] out_src_q, out_src_d, err_src_q, err_src_d;
    logic          err_oversize_q, err_oversize_d, err_timeout_q, err_timeout_d;

    logic [N_SRC-1:0] ready;
    logic             hs, hs_last;
    logic [7:0]       hs_data;
    logic             found;
    logic [SW-1:0]    pick;
    int unsigned      idx;

    assign grant_next = (grant_q == SW'(N_SRC - 1)) ? '0 : grant_q + SW'(1);

    // Ready depends on registered state only, never on src_valid.
    always_comb begin
        ready = '0;
        if (state_q != StArb) ready[grant_q] = 1'b1;
    end

    assign hs      = (state_q != StArb) && bus.src_valid[grant_q];
    assign hs_last = bus.src_last[grant_q];
    assign hs_data = bus.src_data[8*grant_q +: 8];

    // First valid source at or after rr_ptr, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = rr_ptr_q;
        idx   = 0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            idx = (32'(rr_ptr_q) + k) % N_SRC;
            if (!found && bus.src_valid[idx]) begin
                found = 1'b1;
                pick  = SW'(idx);
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        rr_ptr_d       = rr_ptr_q;
        byte_cnt_d     = byte_cnt_q;
        stall_cnt_d    = stall_cnt_q;
        out_data_d     = out_data_q;
        out_valid_d    = 1'b0;
        out_last_d     = 1'b0;
        out_src_d      = out_src_q;
        err_oversize_d = 1'b0;
        err_timeout_d  = 1'b0;
        err_src_d      = err_src_q;
        case (state_q)
            StArb: begin
                if (found) begin
                    grant_d     = pick;
                    byte_cnt_d  = '0;
                    stall_cnt_d = '0;
                    state_d     = StStream;
                end
            end
            StStream, StDrain: begin
                if (hs) begin
                    stall_cnt_d = '0;
                    if (state_q == StDrain) begin
                        if (hs_last) begin
                            rr_ptr_d = grant_next;
                            state_d  = StArb;
                        end
                    end else if (byte_cnt_q == BW'(MAX_NAL_BYTES)) begin
                        // Byte MAX+1 is swallowed; the rest of the unit is drained.
                        err_oversize_d = 1'b1;
                        err_src_d      = grant_q;
                        if (hs_last) begin
                            rr_ptr_d = grant_next;
                            state_d  = StArb;
                        end else begin
                            state_d = StDrain;
                        end
                    end else begin
                        out_valid_d = 1'b1;
                        out_data_d  = hs_data;
                        out_last_d  = hs_last;
                        out_src_d   = grant_q;
                        byte_cnt_d  = byte_cnt_q + BW'(1);
                        if (hs_last) begin
                            rr_ptr_d = grant_next;
                            state_d  = StArb;
                        end
                    end
                end else if (stall_cnt_q == TW'(TIMEOUT - 1)) begin
                    err_timeout_d = 1'b1;
                    err_src_d     = grant_q;
                    rr_ptr_d      = grant_next;
                    state_d       = StArb;
                end else begin
                    stall_cnt_d = stall_cnt_q + TW'(1);
                end
            end
            default: state_d = StArb;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StArb;
            grant_q        <= '0;
            rr_ptr_q       <= '0;
            byte_cnt_q     <= '0;
            stall_cnt_q    <= '0;
            out_data_q     <= '0;
            out_valid_q    <= 1'b0;
            out_last_q     <= 1'b0;
            out_src_q      <= '0;
            err_oversize_q <= 1'b0;
            err_timeout_q  <= 1'b0;
            err_src_q      <= '0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            rr_ptr_q       <= rr_ptr_d;
            byte_cnt_q     <= byte_cnt_d;
            stall_cnt_q    <= stall_cnt_d;
            out_data_q     <= out_data_d;
            out_valid_q    <= out_valid_d;
            out_last_q     <= out_last_d;
            out_src_q      <= out_src_d;
            err_oversize_q <= err_oversize_d;
            err_timeout_q  <= err_timeout_d;
            err_src_q      <= err_src_d;
        end
    end

    assign bus.src_ready    = ready;
    assign bus.out_data     = out_data_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_last     = out_last_q;
    assign bus.out_src      = out_src_q;
    assign bus.err_oversize = err_oversize_q;
    assign bus.err_timeout  = err_timeout_q;
    assign bus.err_src      = err_src_q;
    assign bus.busy         = (state_q != StArb);
endmodule

// File: tb/tb_nal_stream_arbiter.sv
// Bench for nal_stream_arbiter: per-camera NAL queues drive the sources, and a NAL-level
// round-robin model predicts the forwarded byte stream and the error pulses.
module tb_nal_stream_arbiter;
    localparam int N_SRC = 4;
    localparam int MAX_NAL_BYTES = 384;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    nal_stream_arbiter_if #(.N_SRC(N_SRC)) bus ();

    nal_stream_arbiter #(
        .N_SRC(N_SRC),
        .MAX_NAL_BYTES(MAX_NAL_BYTES),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int m_rr = 0;

    logic [8:0] sq [N_SRC][$];  // {last, data} still to be sent
    logic [8:0] mq [N_SRC][$];  // copy consumed by the model
    int pause_after [N_SRC];
    int pause_len [N_SRC];
    int popped [N_SRC];
    bit stall_en;

    // Entries encoded as src*512 + last*256 + data.
    int got[$], exp[$], got_cyc[$];
    int got_ov[$], exp_ov[$], got_to[$], exp_to[$];
    int gap_viol, prev_cyc, prev_src, to_cyc;
    bit prev_last;

    function automatic string q_str(input int q[$]);
        string s = "";
        foreach (q[k]) s = {s, $sformatf("%0d,", q[k])};
        return s;
    endfunction

    function automatic int first_diff();
        for (int k = 0; k < got.size() && k < exp.size(); k++)
            if (got[k] != exp[k]) return k;
        if (got.size() != exp.size()) return (got.size() < exp.size()) ? got.size() : exp.size();
        return -1;
    endfunction

    function automatic int ent(input int q[$], input int k);
        return (k >= 0 && k < q.size()) ? q[k] : -1;
    endfunction

    task automatic clear_obs();
        got.delete(); exp.delete(); got_cyc.delete();
        got_ov.delete(); exp_ov.delete(); got_to.delete(); exp_to.delete();
        gap_viol = 0; prev_cyc = -10; prev_src = -1; prev_last = 1'b0; to_cyc = -1;
        stall_en = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            sq[i].delete(); mq[i].delete();
            pause_after[i] = -1; pause_len[i] = 0;
        end
    endtask

    task automatic apply_reset();
        bus.src_valid = '0; bus.src_data = '0; bus.src_last = '0;
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        m_rr = 0;
    endtask

    task automatic add_nal(input int s, input int len);
        logic [8:0] e;
        for (int b = 0; b < len; b++) begin
            e = {(b == len - 1), 8'($urandom)};
            sq[s].push_back(e);
            mq[s].push_back(e);
        end
    endtask

    // NAL-level reference: pick the next pending source round-robin, forward up to the limit.
    task automatic model_run();
        int s, c;
        logic [8:0] e;
        logic [8:0] nal[$];
        while (1) begin
            s = -1;
            for (int k = 0; k < N_SRC; k++) begin
                c = (m_rr + k) % N_SRC;
                if (s < 0 && mq[c].size() > 0) s = c;
            end
            if (s < 0) break;
            nal.delete();
            e = 9'h000;
            while (mq[s].size() > 0 && !e[8]) begin
                e = mq[s].pop_front();
                nal.push_back(e);
            end
            foreach (nal[b])
                if (b < MAX_NAL_BYTES) exp.push_back(s * 512 + int'(nal[b][8]) * 256 + int'(nal[b][7:0]));
            if (nal.size() > MAX_NAL_BYTES) exp_ov.push_back(s);
            m_rr = (s + 1) % N_SRC;
        end
    endtask

    task automatic sample();
        int src;
        if (bus.out_valid) begin
            src = int'(bus.out_src);
            if (cyc == prev_cyc + 1 && (prev_last || src != prev_src)) gap_viol++;
            got.push_back(src * 512 + int'(bus.out_last) * 256 + int'(bus.out_data));
            got_cyc.push_back(cyc);
            prev_cyc = cyc; prev_src = src; prev_last = bus.out_last;
        end
        if (bus.err_oversize) got_ov.push_back(int'(bus.err_src));
        if (bus.err_timeout) begin
            got_to.push_back(int'(bus.err_src));
            to_cyc = cyc;
        end
    endtask

    task automatic run_traffic(input int max_cycles);
        logic [N_SRC-1:0] v, l, hs_mask;
        logic [N_SRC*8-1:0] d;
        logic [8:0] e;
        bit at_start [N_SRC];
        int srun [N_SRC];
        int idle, n;
        bit done, stall, empty;
        for (int i = 0; i < N_SRC; i++) begin
            at_start[i] = 1'b1; srun[i] = 0; popped[i] = 0;
        end
        hs_mask = '0; idle = 0; n = 0; done = 1'b0;
        while (!done && n < max_cycles) begin
            @(negedge clk);
            cyc++; n++;
            for (int i = 0; i < N_SRC; i++)
                if (hs_mask[i]) begin
                    e = sq[i].pop_front();
                    at_start[i] = e[8];
                    popped[i]++;
                end
            sample();
            v = '0; l = '0; d = '0; empty = 1'b1;
            for (int i = 0; i < N_SRC; i++) begin
                if (sq[i].size() > 0) begin
                    empty = 1'b0;
                    stall = 1'b0;
                    if (popped[i] == pause_after[i] && pause_len[i] > 0) begin
                        stall = 1'b1;
                        pause_len[i]--;
                    end else if (stall_en && !at_start[i] && srun[i] < 5 && $urandom_range(3) == 0) begin
                        stall = 1'b1;
                    end
                    srun[i] = stall ? srun[i] + 1 : 0;
                    if (!stall) begin
                        v[i] = 1'b1;
                        l[i] = sq[i][0][8];
                        d[i*8 +: 8] = sq[i][0][7:0];
                    end
                end
            end
            bus.src_valid = v; bus.src_last = l; bus.src_data = d;
            hs_mask = v & bus.src_ready;
            if (empty && !bus.busy && !bus.out_valid) idle++;
            else idle = 0;
            if (idle >= 3) done = 1'b1;
        end
        bus.src_valid = '0; bus.src_last = '0; bus.src_data = '0;
        total++;
        if (!done) begin
            bad++;
            $display("FAIL run_bound: traffic still pending after %0d cycles, required drained", max_cycles);
        end
    endtask

    task automatic test_reset();
        bus.src_valid = '0; bus.src_data = '0; bus.src_last = '0;
        reset_n = 1'b0;
        @(negedge clk);
        total++; if (bus.src_ready !== '0) begin bad++; $display("FAIL reset_ready: got %b want 0", bus.src_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        total++; if (bus.out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last: got %b want 0", bus.out_last); end
        total++; if (bus.out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data: got %h want 00", bus.out_data); end
        total++; if (bus.out_src !== '0) begin bad++; $display("FAIL reset_out_src: got %0d want 0", bus.out_src); end
        total++; if ({bus.err_oversize, bus.err_timeout} !== 2'b00) begin bad++; $display("FAIL reset_err: got %b want 00", {bus.err_oversize, bus.err_timeout}); end
        total++; if (bus.err_src !== '0) begin bad++; $display("FAIL reset_err_src: got %0d want 0", bus.err_src); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        total++; if ({bus.busy, bus.src_ready, bus.out_valid} !== '0) begin bad++; $display("FAIL idle_after_reset: got %b want 0", {bus.busy, bus.src_ready, bus.out_valid}); end
    endtask

    task automatic test_single();
        int st, k;
        apply_reset(); clear_obs();
        add_nal(0, 10); model_run();
        st = cyc + 1;
        run_traffic(200);
        k = first_diff();
        total++; if (k != -1) begin bad++; $display("FAIL single_bytes: at %0d got %0d want %0d (count %0d/%0d)", k, ent(got, k), ent(exp, k), got.size(), exp.size()); end
        total++; if (got_cyc.size() != 10 || ent(got_cyc, 0) != st + 2 || ent(got_cyc, 9) != st + 11) begin
            bad++; $display("FAIL single_timing: got first=%0d last=%0d n=%0d want first=%0d last=%0d n=10", ent(got_cyc, 0), ent(got_cyc, 9), got_cyc.size(), st + 2, st + 11);
        end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL single_back_to_arb: busy=%b want 0", bus.busy); end
    endtask

    task automatic test_round_robin();
        int k;
        string order;
        apply_reset(); clear_obs();
        for (int r = 0; r < 2; r++) begin add_nal(0, 4); add_nal(1, 4); add_nal(3, 4); end
        model_run();
        run_traffic(300);
        k = first_diff();
        total++; if (k != -1) begin bad++; $display("FAIL rr_bytes: at %0d got %0d want %0d", k, ent(got, k), ent(exp, k)); end
        order = "";
        foreach (got[j]) if (got[j] % 512 >= 256) order = {order, $sformatf("%0d,", got[j] / 512)};
        total++; if (order != "0,1,3,0,1,3,") begin bad++; $display("FAIL rr_order: got %s want 0,1,3,0,1,3,", order); end
        total++; if (gap_viol != 0) begin bad++; $display("FAIL rr_gap: got %0d violations want 0", gap_viol); end
        total++; if (ent(got_cyc, 23) - ent(got_cyc, 0) != 28) begin bad++; $display("FAIL rr_span: got %0d cycles want 28", ent(got_cyc, 23) - ent(got_cyc, 0)); end
    endtask

    task automatic test_oversize();
        int k, n2, l2;
        apply_reset(); clear_obs();
        add_nal(2, 400); add_nal(3, 5); add_nal(0, 3);
        model_run();
        run_traffic(1000);
        k = first_diff();
        total++; if (k != -1) begin bad++; $display("FAIL oversize_bytes: at %0d got %0d want %0d", k, ent(got, k), ent(exp, k)); end
        n2 = 0; l2 = 0;
        foreach (got[j]) if (got[j] / 512 == 2) begin n2++; if (got[j] % 512 >= 256) l2++; end
        total++; if (n2 != 384 || l2 != 0) begin bad++; $display("FAIL oversize_count: got %0d bytes %0d lasts want 384 bytes 0 lasts", n2, l2); end
        total++; if (q_str(got_ov) != "2,") begin bad++; $display("FAIL oversize_err: got %s want 2,", q_str(got_ov)); end
        total++; if (q_str(got_to) != "") begin bad++; $display("FAIL oversize_no_timeout: got %s want none", q_str(got_to)); end
    endtask

    task automatic test_boundary();
        int k;
        apply_reset(); clear_obs();
        add_nal(1, 384); add_nal(1, 385); add_nal(2, 2);
        model_run();
        run_traffic(1500);
        k = first_diff();
        total++; if (k != -1) begin bad++; $display("FAIL boundary_bytes: at %0d got %0d want %0d", k, ent(got, k), ent(exp, k)); end
        total++; if (ent(got, 383) / 256 != 3) begin bad++; $display("FAIL boundary_last: got entry %0d want src1 with last", ent(got, 383)); end
        total++; if (q_str(got_ov) != q_str(exp_ov)) begin bad++; $display("FAIL boundary_err: got %s want %s", q_str(got_ov), q_str(exp_ov)); end
    endtask

    task automatic test_stall();
        int k;
        apply_reset(); clear_obs();
        add_nal(0, 10); add_nal(1, 4);
        pause_after[0] = 5; pause_len[0] = 16;
        for (int b = 0; b < 5; b++) exp.push_back(int'(mq[0][b][7:0]));
        foreach (mq[1][b]) exp.push_back(512 + int'(mq[1][b][8]) * 256 + int'(mq[1][b][7:0]));
        for (int b = 5; b < 10; b++) exp.push_back(int'(mq[0][b][8]) * 256 + int'(mq[0][b][7:0]));
        run_traffic(300);
        k = first_diff();
        total++; if (k != -1) begin bad++; $display("FAIL stall_bytes: at %0d got %0d want %0d", k, ent(got, k), ent(exp, k)); end
        total++; if (q_str(got_to) != "0,") begin bad++; $display("FAIL stall_err: got %s want 0,", q_str(got_to)); end
        total++; if (to_cyc != ent(got_cyc, 4) + 16) begin bad++; $display("FAIL stall_timing: err at %0d want %0d", to_cyc, ent(got_cyc, 4) + 16); end

        apply_reset(); clear_obs();
        add_nal(0, 10); add_nal(1, 4);
        pause_after[0] = 5; pause_len[0] = 15;
        model_run();
        run_traffic(300);
        k = first_diff();
        total++; if (k != -1) begin bad++; $display("FAIL stall_edge_bytes: at %0d got %0d want %0d", k, ent(got, k), ent(exp, k)); end
        total++; if (q_str(got_to) != "") begin bad++; $display("FAIL stall_edge_err: got %s want none", q_str(got_to)); end
    endtask

    task automatic test_reset_mid_nal();
        int n, k;
        bit prev_rdy, seen_last;
        apply_reset(); clear_obs();
        bus.src_valid = 4'b0010; bus.src_data = 32'h0000_5a00; bus.src_last = '0;
        n = 0; prev_rdy = 1'b0; seen_last = 1'b0;
        for (int c = 0; c < 20 && n < 2; c++) begin
            @(negedge clk);
            if (prev_rdy) n++;
            if (bus.out_last) seen_last = 1'b1;
            prev_rdy = bus.src_ready[1];
        end
        total++; if (n != 2 || seen_last) begin bad++; $display("FAIL midreset_setup: got %0d bytes last=%b want 2 bytes last=0", n, seen_last); end
        #2 reset_n = 1'b0;
        #1;
        total++; if ({bus.src_ready, bus.out_valid, bus.out_last, bus.out_data, bus.out_src, bus.busy} !== '0) begin
            bad++; $display("FAIL midreset_async: ready=%b valid=%b last=%b data=%h src=%0d busy=%b want all 0", bus.src_ready, bus.out_valid, bus.out_last, bus.out_data, bus.out_src, bus.busy);
        end
        bus.src_valid = '0; bus.src_data = '0;
        @(negedge clk);
        reset_n = 1'b1;
        m_rr = 0;
        add_nal(3, 3); add_nal(1, 3); add_nal(0, 3);
        model_run();
        run_traffic(200);
        k = first_diff();
        total++; if (k != -1) begin bad++; $display("FAIL midreset_bytes: at %0d got %0d want %0d", k, ent(got, k), ent(exp, k)); end
        total++; if (ent(got, 0) / 512 != 0) begin bad++; $display("FAIL midreset_restart: first src %0d want 0", ent(got, 0) / 512); end
    endtask

    task automatic test_random();
        int k, cnt;
        apply_reset();
        for (int r = 0; r < 5; r++) begin
            clear_obs();
            stall_en = 1'b1;
            cnt = 0;
            for (int s = 0; s < N_SRC; s++)
                if ($urandom_range(1) == 1 || (s == N_SRC - 1 && cnt == 0))
                    for (int j = 0; j <= int'($urandom_range(2)); j++) begin
                        add_nal(s, ($urandom_range(7) == 0) ? int'($urandom_range(380, 390)) : int'($urandom_range(1, 12)));
                        cnt++;
                    end
            model_run();
            run_traffic(8000);
            k = first_diff();
            total++; if (k != -1) begin bad++; $display("FAIL random%0d_bytes: at %0d got %0d want %0d", r, k, ent(got, k), ent(exp, k)); end
            total++; if (q_str(got_ov) != q_str(exp_ov)) begin bad++; $display("FAIL random%0d_oversize: got %s want %s", r, q_str(got_ov), q_str(exp_ov)); end
            total++; if (q_str(got_to) != "") begin bad++; $display("FAIL random%0d_timeout: got %s want none", r, q_str(got_to)); end
            total++; if (gap_viol != 0) begin bad++; $display("FAIL random%0d_gap: got %0d violations want 0", r, gap_viol); end
        end
    endtask

    initial begin
        clear_obs();
        test_reset();
        test_single();
        test_round_robin();
        test_oversize();
        test_boundary();
        test_stall();
        test_reset_mid_nal();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_bound: simulation exceeded time limit, total=%0d bad=%0d", total, bad);
        $fatal(1, "time limit");
    end
endmodule
